operand_hold_guard: RTL and testbench
=====================================

OPERAND_HOLD_GUARD -- requirements
Module: operand_hold_guard

Interface
REQ-001 The block SHALL have parameter NSLOT, default 2, meaning the number of issue slots guarded.
REQ-002 The block SHALL have parameter NOPS, default 2, meaning the operand buses per slot (S, T, ...).
REQ-003 The block SHALL have parameter WIDTH, default 32, meaning the bits per operand bus.
REQ-004 The block SHALL have parameter DEPTH, default 3, meaning the tracked stages of the wrong flag (0=E, 1=M, 2=W).
REQ-005 The block SHALL have parameter CW, default 16, meaning the hold-counter width.
REQ-006 Phi1  input  1  sole clock, rising edge; one clock; reset is asynchronous and active-low.
REQ-007 Reset_b  input  1  asynchronous active-low reset.
REQ-008 Stall_s1  input  1  freezes all state when 1.
REQ-009 SingleIssue  input  1  single-issue (Mips) mode.
REQ-010 Ignore_r  input  NSLOT  per-slot decode "operands unused" flag.
REQ-011 OpIn_r  input  NSLOT*NOPS*WIDTH  raw R-stage operand buses, slot-major.
REQ-012 OpOut_e  output  NSLOT*NOPS*WIDTH  toggle-suppressed E-stage operand buses.
REQ-013 Wrong_e  output  NSLOT*DEPTH  wrong-flag pipeline, slot-major, stage 0 = E.
REQ-014 StatClr  input  1  synchronous clear of hold counters (OPHOLD_STATS_EN only).
REQ-015 HoldCnt  output  NSLOT*CW  per-slot held-cycle count (OPHOLD_STATS_EN only).

Function
REQ-016 Wrong_r[0] SHALL equal Ignore_r[0].
REQ-017 For k>0, Wrong_r[k] SHALL equal Ignore_r[k] OR (SingleIssue AND any slot j<k has Wrong_r[j]=0).
REQ-018 With Stall_s1=0 and Wrong_r[k]=0, slot k's OpOut_e buses SHALL load OpIn_r on the next edge (latency 1).
REQ-019 With Stall_s1=0 and Wrong_r[k]=1, slot k's OpOut_e SHALL hold its previous value, with zero output toggles.
REQ-020 With Stall_s1=0, Wrong_e stage 0 SHALL load Wrong_r, and stage i SHALL load stage i-1 for each slot.
REQ-021 With Stall_s1=1, every register SHALL hold; stall takes priority over load, hold and count.
REQ-022 Slots SHALL be independent; no slot's held state affects another slot except through REQ-017.
REQ-023 DEPTH=1 SHALL be legal, giving a stage-0-only pipeline.

Reset
REQ-024 Reset_b=0 SHALL asynchronously set OpOut_e=0, all Wrong_e bits=1 and HoldCnt=0.
REQ-025 Reset asserted mid-operation SHALL abort any hold; after release, the first unstalled non-wrong cycle loads normally.

Configuration
REQ-026 The macro OPHOLD_STATS_EN SHALL control the hold counters: defined enables them, undefined removes them.
REQ-027 With OPHOLD_STATS_EN defined, on an unstalled edge with Wrong_r[k]=1, HoldCnt[k] SHALL increment, saturating at 2^CW-1.
REQ-028 With OPHOLD_STATS_EN defined, StatClr=1 SHALL zero all counters on the edge, with priority over increment and regardless of stall.
REQ-029 Without OPHOLD_STATS_EN, HoldCnt SHALL be tied 0, StatClr SHALL be ignored, and no counter flops SHALL exist.

Structure
REQ-030 A shared package torch_ophold_pkg SHALL hold the default parameter constants and the slot/operand bus index helper functions.
REQ-031 One sub-module, ophold_slot, SHALL implement the operand register, wrong shift register and counter for one slot, generated NSLOT times.
REQ-032 The inter-slot wrong chain (REQ-017) SHALL live in the top level.

Verification
REQ-033 Reset with OpIn_r=all 0xA5A5A5A5 and Ignore_r=0, then release -> OpOut_e is 0 until the first edge, then 0xA5A5A5A5.
REQ-034 Slot 0 loads 0x1111; set Ignore_r[0]=1 for 4 cycles while OpIn_r toggles -> OpOut_e stays 0x1111 and HoldCnt[0]=4.
REQ-035 SingleIssue=1 with Ignore_r=00 -> Wrong_r=10 (slot 1 held, slot 0 loads); Wrong_e stage 2 shows slot 1=1 three cycles later.
REQ-036 Stall_s1=1 for 3 cycles during a hold-to-load transition -> all outputs frozen and counters unchanged; the load occurs on the first unstalled edge.
REQ-037 CW=4 with slot 1 wrong for 20 cycles -> HoldCnt[1] saturates at 15; StatClr together with Stall_s1=1 -> counter 0.
REQ-038 OPHOLD_STATS_EN undefined and the REQ-034 stimulus -> the same OpOut_e behaviour and HoldCnt=0.

Source files
------------

// File: rtl/torch_ophold_pkg.sv
// Shared defaults and bus-index helpers for the operand hold guard.
// Flat buses are slot-major: slot, then operand, then bit.
package torch_ophold_pkg;

    localparam int OPHOLD_NSLOT = 2;
    localparam int OPHOLD_NOPS  = 2;
    localparam int OPHOLD_WIDTH = 32;
    localparam int OPHOLD_DEPTH = 3;
    localparam int OPHOLD_CW    = 16;

    // LSB of operand 'op' of slot 'slot' inside a flat slot-major operand bus.
    function automatic int op_bus_lsb(input int slot, input int op, input int nops, input int width);
        return (slot * nops + op) * width;
    endfunction

    // LSB of the whole group of operand buses belonging to 'slot'.
    function automatic int slot_bus_lsb(input int slot, input int nops, input int width);
        return slot * nops * width;
    endfunction

    // LSB of a slot's field in a flat per-slot bus (wrong pipeline, counters).
    function automatic int slot_field_lsb(input int slot, input int field_width);
        return slot * field_width;
    endfunction

endpackage

// File: rtl/ophold_slot.sv
// One issue slot: operand registers that hold while the slot is wrong,
// the wrong-flag pipeline, and an optional held-cycle counter (OPHOLD_STATS_EN).
module ophold_slot
    import torch_ophold_pkg::*;
#(
    parameter int NOPS  = OPHOLD_NOPS,
    parameter int WIDTH = OPHOLD_WIDTH,
    parameter int DEPTH = OPHOLD_DEPTH,
    parameter int CW    = OPHOLD_CW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    stat_clr,
    input  logic                    wrong_r,
    input  logic [NOPS*WIDTH-1:0]   op_in,
    output logic [NOPS*WIDTH-1:0]   op_out,
    output logic [DEPTH-1:0]        wrong_e,
    output logic [CW-1:0]           hold_cnt
);

    logic             load_en;
    logic [DEPTH-1:0] wrong_reg;
    logic [DEPTH-1:0] wrong_next;

    // A wrong slot keeps its old operands so downstream logic sees no toggles.
    assign load_en = !stall && !wrong_r;

    for (genvar gi = 0; gi < NOPS; gi++) begin : g_op
        logic [WIDTH-1:0] op_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                op_reg <= '0;
            end else if (load_en) begin
                op_reg <= op_in[op_bus_lsb(0, gi, NOPS, WIDTH) +: WIDTH];
            end
        end

        assign op_out[op_bus_lsb(0, gi, NOPS, WIDTH) +: WIDTH] = op_reg;
    end

    if (DEPTH == 1) begin : g_wrong_single
        assign wrong_next = wrong_r;
    end else begin : g_wrong_shift
        assign wrong_next = {wrong_reg[DEPTH-2:0], wrong_r};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrong_reg <= '1;
        end else if (!stall) begin
            wrong_reg <= wrong_next;
        end
    end

    assign wrong_e = wrong_reg;

`ifdef OPHOLD_STATS_EN
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] cnt_reg;

    // Clear wins over stall so software can zero statistics while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (stat_clr) begin
            cnt_reg <= '0;
        end else if (!stall && wrong_r && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign hold_cnt = cnt_reg;
`else
    logic stat_clr_unused;

    assign stat_clr_unused = stat_clr;
    assign hold_cnt        = '0;
`endif

endmodule

// File: rtl/operand_hold_guard.sv
// Operand toggle-suppression guard: computes the inter-slot wrong chain and
// instantiates one ophold_slot per issue slot. Optional counters: OPHOLD_STATS_EN.
module operand_hold_guard
    import torch_ophold_pkg::*;
#(
    parameter int NSLOT = OPHOLD_NSLOT,
    parameter int NOPS  = OPHOLD_NOPS,
    parameter int WIDTH = OPHOLD_WIDTH,
    parameter int DEPTH = OPHOLD_DEPTH,
    parameter int CW    = OPHOLD_CW
) (
    input  logic                          Phi1,
    input  logic                          Reset_b,
    input  logic                          Stall_s1,
    input  logic                          SingleIssue,
    input  logic [NSLOT-1:0]              Ignore_r,
    input  logic [NSLOT*NOPS*WIDTH-1:0]   OpIn_r,
    output logic [NSLOT*NOPS*WIDTH-1:0]   OpOut_e,
    output logic [NSLOT*DEPTH-1:0]        Wrong_e,
    input  logic                          StatClr,
    output logic [NSLOT*CW-1:0]           HoldCnt
);

    logic [NSLOT-1:0] wrong_r;

    // In single-issue mode only the first valid slot issues; every later slot is wrong.
    always_comb begin
        logic valid_seen;
        wrong_r    = '0;
        valid_seen = 1'b0;
        for (int k = 0; k < NSLOT; k++) begin
            wrong_r[k] = Ignore_r[k] | (SingleIssue & valid_seen);
            valid_seen = valid_seen | ~wrong_r[k];
        end
    end

    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
        ophold_slot #(
            .NOPS  (NOPS),
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_slot (
            .clk      (Phi1),
            .rst_n    (Reset_b),
            .stall    (Stall_s1),
            .stat_clr (StatClr),
            .wrong_r  (wrong_r[gi]),
            .op_in    (OpIn_r[slot_bus_lsb(gi, NOPS, WIDTH) +: NOPS*WIDTH]),
            .op_out   (OpOut_e[slot_bus_lsb(gi, NOPS, WIDTH) +: NOPS*WIDTH]),
            .wrong_e  (Wrong_e[slot_field_lsb(gi, DEPTH) +: DEPTH]),
            .hold_cnt (HoldCnt[slot_field_lsb(gi, CW) +: CW])
        );
    end

endmodule

// File: tb/tb_operand_hold_guard.sv
// Directed bench for operand_hold_guard with a reference model feeding a scoreboard queue.
module tb_operand_hold_guard;

    localparam int NS = 2;
    localparam int NO = 2;
    localparam int W  = 32;
    localparam int D  = 3;
    localparam int C  = 4;
    localparam int OPW = NS*NO*W;
`ifdef OPHOLD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             Phi1 = 1'b0;
    logic             Reset_b;
    logic             Stall_s1;
    logic             SingleIssue;
    logic [NS-1:0]    Ignore_r;
    logic [OPW-1:0]   OpIn_r;
    logic [OPW-1:0]   OpOut_e;
    logic [NS*D-1:0]  Wrong_e;
    logic             StatClr;
    logic [NS*C-1:0]  HoldCnt;

    operand_hold_guard #(.NSLOT(NS), .NOPS(NO), .WIDTH(W), .DEPTH(D), .CW(C)) dut (
        .Phi1        (Phi1),
        .Reset_b     (Reset_b),
        .Stall_s1    (Stall_s1),
        .SingleIssue (SingleIssue),
        .Ignore_r    (Ignore_r),
        .OpIn_r      (OpIn_r),
        .OpOut_e     (OpOut_e),
        .Wrong_e     (Wrong_e),
        .StatClr     (StatClr),
        .HoldCnt     (HoldCnt)
    );

    always #5 Phi1 = ~Phi1;

    typedef struct {
        string           tag;
        logic [OPW-1:0]  op;
        logic [NS*D-1:0] we;
        logic [NS*C-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    logic [OPW-1:0]  m_op;
    logic [NS*D-1:0] m_we;
    logic [NS*C-1:0] m_cnt;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_op  = '0;
        m_we  = '1;
        m_cnt = '0;
    endtask

    // One clock of stimulus: model predicts, scoreboard holds the prediction, DUT is compared after the edge.
    task automatic step(input logic st, input logic si, input logic [NS-1:0] ign,
                        input logic [OPW-1:0] opin, input logic clr, input string tag);
        logic [NS-1:0] wr;
        logic          any_valid;
        exp_t          e;
        Stall_s1    = st;
        SingleIssue = si;
        Ignore_r    = ign;
        OpIn_r      = opin;
        StatClr     = clr;
        any_valid   = 1'b0;
        for (int k = 0; k < NS; k++) begin
            wr[k]     = ign[k] | (si & any_valid);
            any_valid = any_valid | ~wr[k];
        end
        for (int k = 0; k < NS; k++) begin
            if (STATS && clr) begin
                m_cnt[k*C +: C] = '0;
            end else if (STATS && !st && wr[k] && m_cnt[k*C +: C] != 4'hF) begin
                m_cnt[k*C +: C] = m_cnt[k*C +: C] + 4'd1;
            end
            if (!st) begin
                if (!wr[k]) m_op[k*NO*W +: NO*W] = opin[k*NO*W +: NO*W];
                for (int i = D-1; i > 0; i--) m_we[k*D+i] = m_we[k*D+i-1];
                m_we[k*D] = wr[k];
            end
        end
        e.tag = tag;
        e.op  = m_op;
        e.we  = m_we;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge Phi1);
        #1;
        chk({tag, "_sb_nonempty"}, OPW'(sb.size() != 0), OPW'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, "_op"},  OpOut_e,       e.op);
            chk({e.tag, "_we"},  OPW'(Wrong_e), OPW'(e.we));
            chk({e.tag, "_cnt"}, OPW'(HoldCnt), OPW'(e.cnt));
        end
    endtask

    // Assert reset just after an edge, check it holds across an edge, release before the next one.
    task automatic do_reset(input string tag);
        Reset_b = 1'b0;
        model_reset();
        #1;
        chk({tag, "_rst_op"},  OpOut_e,       '0);
        chk({tag, "_rst_we"},  OPW'(Wrong_e), OPW'({NS*D{1'b1}}));
        chk({tag, "_rst_cnt"}, OPW'(HoldCnt), '0);
        @(posedge Phi1);
        #1;
        chk({tag, "_rst_hold_op"}, OpOut_e, '0);
        Reset_b = 1'b1;
        #1;
        chk({tag, "_rel_op"}, OpOut_e, '0);
    endtask

    function automatic logic [OPW-1:0] rnd_ops();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [OPW-1:0] pat;
        logic [OPW-1:0] slot0_1111;
        Reset_b     = 1'b0;
        Stall_s1    = 1'b0;
        SingleIssue = 1'b0;
        Ignore_r    = '0;
        StatClr     = 1'b0;
        OpIn_r      = {(OPW/32){32'hA5A5_A5A5}};
        model_reset();
        @(posedge Phi1);
        #1;

        // Reset, release, first edge loads A5 pattern
        do_reset("r33");
        step(1'b0, 1'b0, 2'b00, {(OPW/32){32'hA5A5_A5A5}}, 1'b0, "r33_load");
        chk("r33_a5", OpOut_e, {(OPW/32){32'hA5A5_A5A5}});

        // Slot 0 loads 0x1111 then is ignored for 4 cycles while inputs toggle
        slot0_1111 = {64'h0, 32'h0000_1111, 32'h0000_1111};
        step(1'b0, 1'b0, 2'b00, slot0_1111, 1'b0, "r34_load");
        for (int i = 0; i < 4; i++) begin
            pat = rnd_ops();
            step(1'b0, 1'b0, 2'b01, pat, 1'b0, $sformatf("r34_hold%0d", i));
        end
        chk("r34_slot0", OPW'(OpOut_e[NO*W-1:0]), OPW'({32'h0000_1111, 32'h0000_1111}));
        chk("r34_cnt0",  OPW'(HoldCnt[C-1:0]),    OPW'(STATS ? 4'd4 : 4'd0));

        // Single-issue: slot 1 becomes wrong, reaches stage 2 after three edges
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 2'b00, rnd_ops(), 1'b0, $sformatf("r35_si%0d", i));
        end
        chk("r35_s1_stage2", OPW'(Wrong_e[1*D+2]), OPW'(1'b1));
        chk("r35_s0_stage0", OPW'(Wrong_e[0]),     OPW'(1'b0));

        // Hold then stall across the hold-to-load transition
        step(1'b0, 1'b0, 2'b11, rnd_ops(), 1'b0, "r36_hold");
        pat = OpOut_e;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 2'b00, rnd_ops(), 1'b0, $sformatf("r36_stall%0d", i));
        end
        chk("r36_frozen", OpOut_e, pat);
        pat = rnd_ops();
        step(1'b0, 1'b0, 2'b00, pat, 1'b0, "r36_release");
        chk("r36_loaded", OpOut_e, pat);

        // Slot 1 wrong for 20 cycles saturates its counter; clear works during stall
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 2'b10, rnd_ops(), 1'b0, $sformatf("r37_wr%0d", i));
        end
        chk("r37_sat", OPW'(HoldCnt[2*C-1:C]), OPW'(STATS ? 4'd15 : 4'd0));
        step(1'b1, 1'b0, 2'b10, rnd_ops(), 1'b1, "r37_clr");
        chk("r37_cleared", OPW'(HoldCnt), '0);

        // Mixed random traffic
        for (int i = 0; i < 16; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 rnd_ops(), 1'($urandom_range(0, 7) == 0), $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a hold, then a normal load
        step(1'b0, 1'b0, 2'b11, rnd_ops(), 1'b0, "r25_hold");
        do_reset("r25");
        pat = rnd_ops();
        step(1'b0, 1'b0, 2'b00, pat, 1'b0, "r25_load");
        chk("r25_loaded", OpOut_e, pat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
